// File: rtl/wb_gpio_arb_if.sv
// Bus bundle between the two Wishbone masters, the arbiter and the GPIO slave port.
// "slave" is the arbiter's view: it answers both masters and drives the GPIO slave
// port. "master" is the view of everything around the arbiter: both bus masters
// plus the GPIO slave's ack/read-data return path.
interface wb_gpio_arb_if #(
   parameter int wb_dat_width = 32,
   parameter int wb_adr_width = 32
);
   logic [wb_adr_width-1:0] m0_adr_i, m1_adr_i;
   logic [wb_dat_width-1:0] m0_dat_i, m1_dat_i;
   logic                    m0_we_i, m1_we_i;
   logic                    m0_cyc_i, m1_cyc_i;
   logic                    m0_stb_i, m1_stb_i;
   logic                    m0_ack_o, m1_ack_o;
   logic                    m0_err_o, m1_err_o;
   logic [wb_dat_width-1:0] m0_dat_o, m1_dat_o;

   logic [wb_adr_width-1:0] s_adr_o;
   logic [wb_dat_width-1:0] s_dat_o;
   logic                    s_we_o, s_cyc_o, s_stb_o;
   logic                    s_ack_i;
   logic [wb_dat_width-1:0] s_dat_i;

   modport slave (
      input  m0_adr_i, m1_adr_i, m0_dat_i, m1_dat_i, m0_we_i, m1_we_i,
             m0_cyc_i, m1_cyc_i, m0_stb_i, m1_stb_i, s_ack_i, s_dat_i,
      output m0_ack_o, m1_ack_o, m0_err_o, m1_err_o, m0_dat_o, m1_dat_o,
             s_adr_o, s_dat_o, s_we_o, s_cyc_o, s_stb_o
   );

   modport master (
      output m0_adr_i, m1_adr_i, m0_dat_i, m1_dat_i, m0_we_i, m1_we_i,
             m0_cyc_i, m1_cyc_i, m0_stb_i, m1_stb_i, s_ack_i, s_dat_i,
      input  m0_ack_o, m1_ack_o, m0_err_o, m1_err_o, m0_dat_o, m1_dat_o,
             s_adr_o, s_dat_o, s_we_o, s_cyc_o, s_stb_o
   );
endinterface

// File: rtl/wb_gpio_arb.sv
// Two-master Wishbone arbiter in front of the GPIO slave port.
// The grant is held for as long as the granted master keeps CYC high. Ties are
// broken round-robin. A granted STB that waits too long for ACK is aborted with
// a one-cycle ERR.
//
// state | meaning
// ------+------------------------------------------------
// IDLE  | no grant, slave bus quiet
// GNT0  | master 0 owns the slave until it drops CYC
// GNT1  | master 1 owns the slave until it drops CYC
module wb_gpio_arb #(
   parameter int wb_dat_width   = 32,
   parameter int wb_adr_width   = 32,
   parameter int timeout_cycles = 16
) (
   input  logic       clk,
   input  logic       rst,
   wb_gpio_arb_if.slave bus,
   output logic [1:0] grant_o
);

   typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

   localparam logic [15:0] TIMEOUT = 16'(timeout_cycles);

   state_t      state_q, state_d;
   logic        last_gnt_q, last_gnt_d;
   logic [15:0] cnt_q, cnt_d;
   logic        to_hit;

   // Read data is broadcast; the ack qualifies it.
   assign bus.m0_dat_o = bus.s_dat_i;
   assign bus.m1_dat_o = bus.s_dat_i;

   // State, round-robin pointer and timeout counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         last_gnt_q <= 1'b1;
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         last_gnt_q <= last_gnt_d;
         cnt_q      <= cnt_d;
      end
   end

   // Next-state, slave mux, ack/err routing and timeout accounting.
   always_comb begin
      state_d      = state_q;
      last_gnt_d   = last_gnt_q;
      cnt_d        = '0;
      grant_o      = 2'b00;
      bus.s_adr_o  = '0;
      bus.s_dat_o  = '0;
      bus.s_we_o   = 1'b0;
      bus.s_cyc_o  = 1'b0;
      bus.s_stb_o  = 1'b0;
      bus.m0_ack_o = 1'b0;
      bus.m1_ack_o = 1'b0;
      bus.m0_err_o = 1'b0;
      bus.m1_err_o = 1'b0;
      to_hit       = (state_q != IDLE) && (cnt_q == TIMEOUT);

      case (state_q)
         IDLE: begin
            if (bus.m0_cyc_i && bus.m1_cyc_i)
               state_d = last_gnt_q ? GNT0 : GNT1;
            else if (bus.m0_cyc_i)
               state_d = GNT0;
            else if (bus.m1_cyc_i)
               state_d = GNT1;
         end
         GNT0: begin
            grant_o      = 2'b01;
            bus.s_adr_o  = bus.m0_adr_i;
            bus.s_dat_o  = bus.m0_dat_i;
            bus.s_we_o   = bus.m0_we_i;
            bus.s_cyc_o  = bus.m0_cyc_i & ~to_hit;
            bus.s_stb_o  = bus.m0_stb_i & ~to_hit;
            bus.m0_ack_o = bus.s_ack_i & bus.m0_cyc_i & bus.m0_stb_i;
            // a late ack in the timeout cycle still completes the access
            bus.m0_err_o = to_hit & ~bus.s_ack_i & bus.m0_cyc_i;
            if (bus.s_stb_o && !bus.s_ack_i)
               cnt_d = cnt_q + 16'd1;
            if (!bus.m0_cyc_i) begin
               last_gnt_d = 1'b0;
               cnt_d      = '0;
               state_d    = bus.m1_cyc_i ? GNT1 : IDLE;
            end
         end
         GNT1: begin
            grant_o      = 2'b10;
            bus.s_adr_o  = bus.m1_adr_i;
            bus.s_dat_o  = bus.m1_dat_i;
            bus.s_we_o   = bus.m1_we_i;
            bus.s_cyc_o  = bus.m1_cyc_i & ~to_hit;
            bus.s_stb_o  = bus.m1_stb_i & ~to_hit;
            bus.m1_ack_o = bus.s_ack_i & bus.m1_cyc_i & bus.m1_stb_i;
            bus.m1_err_o = to_hit & ~bus.s_ack_i & bus.m1_cyc_i;
            if (bus.s_stb_o && !bus.s_ack_i)
               cnt_d = cnt_q + 16'd1;
            if (!bus.m1_cyc_i) begin
               last_gnt_d = 1'b1;
               cnt_d      = '0;
               state_d    = bus.m0_cyc_i ? GNT0 : IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_wb_gpio_arb.sv
// Directed bench for wb_gpio_arb: a registered-ack GPIO slave model plus
// hand-timed master stimulus. Inputs change 1 ns after the rising edge,
// outputs are sampled on the falling edge.
module tb_wb_gpio_arb;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [1:0] grant;

   logic        slv_en    = 1'b1;
   logic        force_ack = 1'b0;
   logic        mdl_ack;
   logic [31:0] slv_dat   = 32'h0;

   int n_chk = 0;
   int n_err = 0;

   wb_gpio_arb_if #(.wb_dat_width(32), .wb_adr_width(32)) bus ();

   wb_gpio_arb #(
      .wb_dat_width(32), .wb_adr_width(32), .timeout_cycles(16)
   ) dut (
      .clk(clk), .rst(rst), .bus(bus), .grant_o(grant)
   );

   always #5 clk = ~clk;

   // GPIO slave: registered ack, one pulse per strobe (ack every other cycle
   // when STB is held).
   always @(posedge clk or posedge rst) begin
      if (rst) mdl_ack <= 1'b0;
      else     mdl_ack <= slv_en & bus.s_cyc_o & bus.s_stb_o & ~mdl_ack;
   end
   assign bus.s_ack_i = mdl_ack | force_ack;
   assign bus.s_dat_i = slv_dat;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   task automatic idle_masters();
      bus.m0_adr_i = '0; bus.m0_dat_i = '0; bus.m0_we_i = 1'b0;
      bus.m0_cyc_i = 1'b0; bus.m0_stb_i = 1'b0;
      bus.m1_adr_i = '0; bus.m1_dat_i = '0; bus.m1_we_i = 1'b0;
      bus.m1_cyc_i = 1'b0; bus.m1_stb_i = 1'b0;
   endtask

   task automatic do_reset();
      idle_masters();
      rst = 1'b1;
      tick(); tick();
      rst = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int acks, stb_rise, err_cyc, err_cnt, ack_seen, stb_at_err, cyc_at_err;

      idle_masters();
      tick(); tick();
      smp();
      // reset state
      chk("rst_grant", grant, 2'b00);
      chk("rst_scyc",  bus.s_cyc_o, 1'b0);
      chk("rst_sstb",  bus.s_stb_o, 1'b0);
      chk("rst_swe",   bus.s_we_o, 1'b0);
      chk("rst_sadr",  bus.s_adr_o, 32'h0);
      chk("rst_sdat",  bus.s_dat_o, 32'h0);
      chk("rst_acks",  {bus.m0_ack_o, bus.m1_ack_o}, 2'b00);
      chk("rst_errs",  {bus.m0_err_o, bus.m1_err_o}, 2'b00);
      rst = 1'b0;

      // single write by m0: stb at cycle 1, ack at cycle 2
      tick();
      bus.m0_cyc_i = 1'b1; bus.m0_stb_i = 1'b1; bus.m0_we_i = 1'b1;
      bus.m0_adr_i = 32'h8; bus.m0_dat_i = 32'h1FF;
      smp();
      chk("wr_c0_stb", bus.s_stb_o, 1'b0);
      tick(); smp();
      chk("wr_c1_stb",   bus.s_stb_o, 1'b1);
      chk("wr_c1_grant", grant, 2'b01);
      chk("wr_c1_bus",   {bus.s_we_o, bus.s_adr_o, bus.s_dat_o}, {1'b1, 32'h8, 32'h1FF});
      chk("wr_c1_ack",   bus.m0_ack_o, 1'b0);
      tick(); smp();
      chk("wr_c2_ack0", bus.m0_ack_o, 1'b1);
      chk("wr_c2_ack1", bus.m1_ack_o, 1'b0);
      tick();
      bus.m0_cyc_i = 1'b0; bus.m0_stb_i = 1'b0; bus.m0_we_i = 1'b0;
      tick(); smp();
      chk("wr_idle", grant, 2'b00);

      // round-robin: both request right after reset
      do_reset();
      bus.m0_cyc_i = 1'b1; bus.m0_stb_i = 1'b1; bus.m0_adr_i = 32'h4;
      bus.m1_cyc_i = 1'b1; bus.m1_stb_i = 1'b1; bus.m1_adr_i = 32'hC;
      tick(); smp();
      chk("rr_first", grant, 2'b01);
      chk("rr_first_ack1", bus.m1_ack_o, 1'b0);
      tick();
      bus.m0_cyc_i = 1'b0; bus.m0_stb_i = 1'b0;
      tick(); smp();
      chk("rr_handover", grant, 2'b10);
      chk("rr_handover_adr", bus.s_adr_o, 32'hC);
      tick();
      bus.m1_cyc_i = 1'b0; bus.m1_stb_i = 1'b0;
      tick();
      bus.m0_cyc_i = 1'b1; bus.m1_cyc_i = 1'b1;
      smp();
      chk("rr_idle", grant, 2'b00);
      tick(); smp();
      chk("rr_alternate", grant, 2'b01);
      tick();
      bus.m0_cyc_i = 1'b0; bus.m1_cyc_i = 1'b0;
      tick(); tick();

      // m1 locks the bus over three reads while m0 keeps requesting
      slv_dat = 32'h0A5;
      bus.m1_cyc_i = 1'b1; bus.m1_stb_i = 1'b1; bus.m1_adr_i = 32'h0; bus.m1_we_i = 1'b0;
      bus.m0_cyc_i = 1'b1; bus.m0_stb_i = 1'b1; bus.m0_adr_i = 32'h8;
      acks = 0;
      for (int k = 1; k <= 6; k++) begin
         tick(); smp();
         chk("lock_grant", grant, 2'b10);
         chk("lock_ack0", bus.m0_ack_o, 1'b0);
         if (bus.m1_ack_o) begin
            acks++;
            chk("lock_rdata", bus.m1_dat_o, 32'h000000A5);
         end
      end
      chk("lock_acks", 32'(acks), 32'd3);
      tick();
      bus.m1_cyc_i = 1'b0; bus.m1_stb_i = 1'b0;
      tick(); smp();
      chk("lock_release", grant, 2'b01);
      tick();
      bus.m0_cyc_i = 1'b0; bus.m0_stb_i = 1'b0;
      tick(); tick();

      // timeout with a dead slave
      do_reset();
      slv_en = 1'b0;
      bus.m0_cyc_i = 1'b1; bus.m0_stb_i = 1'b1; bus.m0_adr_i = 32'h0;
      stb_rise = -1; err_cyc = -1; err_cnt = 0; ack_seen = 0;
      stb_at_err = 1; cyc_at_err = 1;
      for (int k = 1; k <= 30; k++) begin
         tick(); smp();
         if (bus.s_stb_o && stb_rise < 0) stb_rise = k;
         if (bus.m0_ack_o) ack_seen = 1;
         if (bus.m0_err_o) begin
            err_cnt++;
            if (err_cyc < 0) begin
               err_cyc    = k;
               stb_at_err = bus.s_stb_o;
               cyc_at_err = bus.s_cyc_o;
            end
         end
      end
      chk("to_stb_rise", 32'(stb_rise), 32'd1);
      chk("to_err_delay", 32'(err_cyc - stb_rise), 32'd16);
      chk("to_err_count", 32'(err_cnt), 32'd1);
      chk("to_stb_forced", 32'(stb_at_err), 32'd0);
      chk("to_cyc_forced", 32'(cyc_at_err), 32'd0);
      chk("to_no_ack", 32'(ack_seen), 32'd0);
      chk("to_grant_kept", grant, 2'b01);
      tick();
      bus.m0_cyc_i = 1'b0; bus.m0_stb_i = 1'b0;
      tick(); tick();

      // ack arrives in the timeout cycle: ack wins, no err
      bus.m0_cyc_i = 1'b1; bus.m0_stb_i = 1'b1;
      repeat (16) tick();
      smp();
      chk("race_c16_err", bus.m0_err_o, 1'b0);
      tick();
      force_ack = 1'b1;
      smp();
      chk("race_c17_ack", bus.m0_ack_o, 1'b1);
      chk("race_c17_err", bus.m0_err_o, 1'b0);
      tick();
      force_ack = 1'b0;
      smp();
      chk("race_c18_err", bus.m0_err_o, 1'b0);
      tick();
      bus.m0_cyc_i = 1'b0; bus.m0_stb_i = 1'b0;
      tick(); tick();

      // async reset while m1 holds a pending strobe
      slv_en = 1'b1;
      bus.m1_cyc_i = 1'b1; bus.m1_stb_i = 1'b1;
      tick(); smp();
      chk("rstm_pre_grant", grant, 2'b10);
      @(posedge clk); #2;
      rst = 1'b1;
      #1;
      chk("rstm_grant", grant, 2'b00);
      chk("rstm_scyc", bus.s_cyc_o, 1'b0);
      chk("rstm_ack1", bus.m1_ack_o, 1'b0);
      chk("rstm_err1", bus.m1_err_o, 1'b0);
      bus.m1_cyc_i = 1'b0; bus.m1_stb_i = 1'b0;
      tick(); smp();
      chk("rstm_hold_ack1", bus.m1_ack_o, 1'b0);
      tick();
      rst = 1'b0;
      bus.m0_cyc_i = 1'b1; bus.m1_cyc_i = 1'b1;
      tick(); smp();
      chk("rstm_tie", grant, 2'b01);
      tick();
      idle_masters();
      tick();

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
